// File: rtl/bfp_scale_ctrl.sv
// Block-floating-point scale controller.
// Watches every butterfly output of one FFT stage and records the largest
// significant magnitude. At the end of the stage it produces the shift_value
// that keeps the next stage inside OUTPUT_WIDTH signed bits. It also keeps a
// running total of the right shifts applied across the frame.
module bfp_scale_ctrl #(
   parameter int DATA_WIDTH   = 23,
   parameter int OUTPUT_WIDTH = 11,
   parameter int SHIFT_WIDTH  = 5,
   parameter int SHIFT_TARGET = 12,
   parameter int FRAME_LEN    = 512,
   parameter int NUM_STAGES   = 9,
   parameter int EXP_WIDTH    = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          in_valid,
   input  logic [DATA_WIDTH-1:0]         in_re,
   input  logic [DATA_WIDTH-1:0]         in_im,
   output logic [SHIFT_WIDTH-1:0]        shift_value,
   output logic                          shift_valid,
   output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
   output logic [EXP_WIDTH-1:0]          exp_total,
   output logic                          busy,
   output logic                          done,
   output logic                          overrun
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam int STG_W = $clog2(NUM_STAGES);
   localparam int EXP_W1 = EXP_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, MEASURE, UPDATE, DONE} state_t;

   state_t state, next_state;

   logic [CNT_W-1:0]        sample_cnt;
   logic [DATA_WIDTH-2:0]   acc;
   logic [DATA_WIDTH-2:0]   mag_re, mag_im;
   logic [SHIFT_WIDTH-1:0]  r_amt;
   logic [SHIFT_WIDTH-1:0]  new_shift;
   logic [EXP_W1-1:0]       exp_sum;
   logic [EXP_WIDTH-1:0]    exp_next;
   logic                    last_sample;
   logic                    last_stage;
   int                      msb;
   int                      r_int;

   // One's-complement folding: negative samples map to the magnitude of their
   // significant bits, so -2^k and 2^k-1 occupy the same number of bits.
   always_comb begin
      mag_re = in_re[DATA_WIDTH-2:0] ^ {(DATA_WIDTH-1){in_re[DATA_WIDTH-1]}};
      mag_im = in_im[DATA_WIDTH-2:0] ^ {(DATA_WIDTH-1){in_im[DATA_WIDTH-1]}};
      last_sample = (sample_cnt == CNT_W'(FRAME_LEN - 1));
      last_stage  = (stage_idx == STG_W'(NUM_STAGES - 1));
   end

   // Find the top set bit of the stage accumulator and derive the right shift
   // needed so the next stage fits OUTPUT_WIDTH signed bits.
   always_comb begin
      msb = -1;
      for (int i = 0; i < DATA_WIDTH - 1; i++) begin
         if (acc[i]) begin
            msb = i;
         end
      end
      r_int = msb + 2 - OUTPUT_WIDTH;
      if (r_int < 0) begin
         r_int = 0;
      end
      if (r_int > SHIFT_TARGET) begin
         r_int = SHIFT_TARGET;
      end
      r_amt     = SHIFT_WIDTH'(r_int);
      new_shift = SHIFT_WIDTH'(SHIFT_TARGET) - r_amt;
      exp_sum   = {1'b0, exp_total} + EXP_W1'(r_amt);
      exp_next  = exp_sum[EXP_WIDTH] ? {EXP_WIDTH{1'b1}} : exp_sum[EXP_WIDTH-1:0];
   end

   // State register; reset aborts any frame in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: frame start, end of stage, end of frame.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = MEASURE;
         MEASURE: if (in_valid && last_sample) next_state = UPDATE;
         UPDATE:  next_state = last_stage ? DONE : MEASURE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath: sample counting, magnitude accumulation, shift/exponent update
   // and the registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt  <= '0;
         acc         <= '0;
         shift_value <= SHIFT_WIDTH'(SHIFT_TARGET);
         shift_valid <= 1'b0;
         stage_idx   <= '0;
         exp_total   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         shift_valid <= 1'b0;
         done        <= (state == DONE);
         busy        <= (next_state == MEASURE) || (next_state == UPDATE);
         case (state)
            IDLE: begin
               if (start) begin
                  sample_cnt  <= '0;
                  acc         <= '0;
                  stage_idx   <= '0;
                  exp_total   <= '0;
                  overrun     <= 1'b0;
                  shift_value <= SHIFT_WIDTH'(SHIFT_TARGET);
               end
            end
            MEASURE: begin
               if (in_valid) begin
                  acc        <= acc | mag_re | mag_im;
                  sample_cnt <= sample_cnt + 1'b1;
               end
            end
            UPDATE: begin
               shift_value <= new_shift;
               exp_total   <= exp_next;
               shift_valid <= 1'b1;
               acc         <= '0;
               sample_cnt  <= '0;
               if (in_valid) begin
                  overrun <= 1'b1;
               end
               if (!last_stage) begin
                  stage_idx <= stage_idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bfp_scale_ctrl.sv
// Self-checking bench for bfp_scale_ctrl with a short frame (4 samples,
// 3 stages). Expected stage results are queued as each stage is driven and
// compared whenever the controller pulses shift_valid.
module tb_bfp_scale_ctrl;

   localparam int DW = 23;
   localparam int SHW = 5;
   localparam int FL = 4;
   localparam int NS = 3;
   localparam int EW = 8;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic           in_valid;
   logic [DW-1:0]  in_re, in_im;
   logic [SHW-1:0] shift_value;
   logic           shift_valid;
   logic [1:0]     stage_idx;
   logic [EW-1:0]  exp_total;
   logic           busy, done, overrun;

   typedef struct {
      int sv;
      int ex;
      int st;
   } expect_t;

   expect_t sb[$];
   int total_cnt = 0;
   int bad_cnt = 0;
   int m_exp;
   int m_stage;

   bfp_scale_ctrl #(
      .DATA_WIDTH(DW), .OUTPUT_WIDTH(11), .SHIFT_WIDTH(SHW), .SHIFT_TARGET(12),
      .FRAME_LEN(FL), .NUM_STAGES(NS), .EXP_WIDTH(EW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_re(in_re), .in_im(in_im), .shift_value(shift_value),
      .shift_valid(shift_valid), .stage_idx(stage_idx), .exp_total(exp_total),
      .busy(busy), .done(done), .overrun(overrun)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int act, input int exp);
      total_cnt++;
      if (act != exp) begin
         bad_cnt++;
         $display("[TB] FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   function automatic int magOf(input int v);
      return (v < 0) ? (-v - 1) : v;
   endfunction

   // Right shift needed so a magnitude m fits 11 signed bits, capped at 12
   function automatic int shiftFor(input int m);
      int p = -1;
      int r;
      while (p < 30 && (1 << (p + 1)) <= m) p++;
      r = p + 2 - 11;
      if (r < 0) r = 0;
      if (r > 12) r = 12;
      return r;
   endfunction

   // Scoreboard consumer: every shift_valid pulse must match the next entry
   always @(negedge clk) begin
      if (shift_valid) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_shift_valid", int'(shift_valid), 0);
         end else begin
            expect_t e;
            e = sb.pop_front();
            checkOutput("shift_value", int'(shift_value), e.sv);
            checkOutput("exp_total", int'(exp_total), e.ex);
            checkOutput("stage_idx", int'(stage_idx), e.st);
         end
      end
   end

   task automatic startFrame();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      m_exp = 0;
      m_stage = 0;
      checkOutput("start_busy", int'(busy), 1);
      checkOutput("start_exp", int'(exp_total), 0);
      checkOutput("start_stage", int'(stage_idx), 0);
      checkOutput("start_shift", int'(shift_value), 12);
      checkOutput("start_overrun", int'(overrun), 0);
      checkOutput("start_done", int'(done), 0);
   endtask

   // Drive one full stage; optional mid-stage gap, in_valid held through the
   // update cycle, and a stray start pulse on the first sample.
   task automatic applyStimulus(input int re[FL], input int im[FL],
                                input bit gap, input bit hold, input bit poke);
      int m = 0;
      int r;
      expect_t e;
      for (int k = 0; k < FL; k++) begin
         if (magOf(re[k]) > m) m = magOf(re[k]);
         if (magOf(im[k]) > m) m = magOf(im[k]);
      end
      r = shiftFor(m);
      m_exp = (m_exp + r > 255) ? 255 : m_exp + r;
      m_stage = (m_stage == NS - 1) ? m_stage : m_stage + 1;
      e.sv = 12 - r;
      e.ex = m_exp;
      e.st = m_stage;
      sb.push_back(e);
      for (int k = 0; k < FL; k++) begin
         in_valid = 1'b1;
         in_re = DW'(re[k]);
         in_im = DW'(im[k]);
         start = poke && (k == 0);
         @(posedge clk); #1;
         start = 1'b0;
         if (gap && k == 1) begin
            in_valid = 1'b0;
            in_re = DW'(1 << 21);
            @(posedge clk); #1;
         end
      end
      if (hold) begin
         in_valid = 1'b1;
         in_re = DW'(1 << 20);
         in_im = '0;
      end else begin
         in_valid = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Last shift_valid cycle has no done; done follows one cycle later
   task automatic waitFrameEnd();
      @(negedge clk);
      checkOutput("done_early", int'(done), 0);
      @(negedge clk);
      checkOutput("done_pulse", int'(done), 1);
      checkOutput("done_busy", int'(busy), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      in_re = '0;
      in_im = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_shift", int'(shift_value), 12);
      checkOutput("rst_shift_valid", int'(shift_valid), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_overrun", int'(overrun), 0);
      checkOutput("rst_stage", int'(stage_idx), 0);
      checkOutput("rst_exp", int'(exp_total), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of the second stage of a frame
      startFrame();
      applyStimulus('{1024, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         in_re = DW'(5);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_shift", int'(shift_value), 12);
      checkOutput("midrst_stage", int'(stage_idx), 0);
      checkOutput("midrst_exp", int'(exp_total), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("midrst_no_done", int'(done), 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Fit boundary, with a mid-stage in_valid gap in the second stage
      startFrame();
      applyStimulus('{1000, -3, 0, 7}, '{0, 0, 0, 0}, 0, 0, 0);
      applyStimulus('{1024, 5, -7, 0}, '{0, 0, 0, 0}, 1, 0, 0);
      applyStimulus('{-1025, 0, 2, 0}, '{0, 0, 0, 0}, 0, 0, 0);
      waitFrameEnd();

      // Full range and all-zero/-1 stage, started back-to-back after done
      startFrame();
      applyStimulus('{2097151, 2097151, 2097151, 2097151}, '{0, 0, 0, 0}, 0, 0, 0);
      applyStimulus('{-4194304, -4194304, -4194304, -4194304}, '{0, 0, 0, 0}, 0, 0, 0);
      applyStimulus('{0, -1, -1, 0}, '{-1, 0, 0, -1}, 0, 0, 0);
      waitFrameEnd();

      // Overrun through the update cycle and a start ignored while busy
      startFrame();
      applyStimulus('{5, 5, 5, 5}, '{0, 0, 0, 0}, 0, 1, 0);
      checkOutput("overrun_set", int'(overrun), 1);
      applyStimulus('{100, -200, 3, 0}, '{0, 0, 0, 0}, 0, 0, 1);
      applyStimulus('{300, 0, 0, 0}, '{0, -2049, 0, 0}, 0, 0, 0);
      waitFrameEnd();
      checkOutput("overrun_sticky", int'(overrun), 1);
      startFrame();

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/bfp_scale_ctrl.md
# bfp_scale_ctrl

Block-floating-point scale controller for the pipelined FFT datapath. It watches every butterfly output sample of one FFT stage and records the largest significant magnitude. At the end of the stage it computes the `shift_value` that the `bit_shift` requantizers use for the next stage, so the next stage's data fits `OUTPUT_WIDTH` signed bits without overflow. It also accumulates the total block exponent for the frame. It sits beside the stage memories and drives the `shift_value` input of all `bit_shift` instances.

## Interface
- `DATA_WIDTH`, 23, width of monitored re/im samples (equals requantizer input width)
- `OUTPUT_WIDTH`, 11, requantizer output width
- `SHIFT_WIDTH`, 5, width of `shift_value`
- `SHIFT_TARGET`, 12, requantizer unity point: effective right shift = `SHIFT_TARGET - shift_value`
- `FRAME_LEN`, 512, samples per stage
- `NUM_STAGES`, 9, stages per FFT frame
- `EXP_WIDTH`, 8, width of `exp_total`
- `clk`  in  1  clock; one clock domain only
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse: begin a new FFT frame
- `in_valid`  in  1  stage output sample valid
- `in_re`, `in_im`  in  `DATA_WIDTH`  signed stage output sample
- `shift_value`  out  `SHIFT_WIDTH`  requantizer control, held between updates
- `shift_valid`  out  1  one-cycle pulse, `shift_value` was just updated
- `stage_idx`  out  `$clog2(NUM_STAGES)`  index of the stage being measured
- `exp_total`  out  `EXP_WIDTH`  sum of right shifts applied in this frame
- `busy`  out  1  high in `MEASURE` and `UPDATE`
- `done`  out  1  one-cycle pulse at frame end
- `overrun`  out  1  sticky error; cleared by `start` or reset

## Operation
- **States:** `IDLE`, `MEASURE`, `UPDATE`, `DONE`.
- **IDLE:**
  - On `start`, clear the sample counter, `acc`, `stage_idx`, `exp_total` and `overrun`.
  - Set `shift_value = SHIFT_TARGET` (unity gain), then go to `MEASURE`.
- **MEASURE:**
  - For each cycle with `in_valid`: `acc |= (in_re ^ {DATA_WIDTH{in_re[MSB]}}) | (in_im ^ {DATA_WIDTH{in_im[MSB]}})`, using bits `[DATA_WIDTH-2:0]`. Increment the sample counter.
  - When the `FRAME_LEN`-th sample is accepted, go to `UPDATE`.
- **UPDATE (1 cycle):**
  - `p` = index of the highest set bit of `acc`, or -1 if `acc` is 0.
  - `r = max(0, p + 2 - OUTPUT_WIDTH)`, clamped to `SHIFT_TARGET`.
  - Register `shift_value = SHIFT_TARGET - r`, set `exp_total += r` (saturating at all-ones), pulse `shift_valid`, clear `acc` and the counter.
  - If `stage_idx == NUM_STAGES-1`, go to `DONE`. Otherwise increment `stage_idx` and return to `MEASURE`.
- **DONE (1 cycle):** pulse `done`, go to `IDLE`. `shift_value` and `exp_total` hold until the next `start`.
- **Ignored inputs:**
  - `start` while not in `IDLE` is ignored.
  - `in_valid` in `IDLE` or `DONE` is ignored.
  - `in_valid` during `UPDATE` is dropped and sets `overrun`. Upstream must leave at least a one-cycle gap between stages.
- **Reset:** `rst_n` low at any time returns to `IDLE` immediately and aborts a frame in progress.

## Timing
- Reset values:
  - `shift_value = SHIFT_TARGET`
  - `shift_valid`, `done`, `busy`, `overrun` = 0
  - `stage_idx` = 0, `exp_total` = 0
- `start` sampled at edge T: `busy` high from T+1, and a sample at T+1 is accepted.
- Last sample of a stage accepted at edge T:
  - The `UPDATE` cycle follows.
  - The new `shift_value`, `shift_valid` pulse and incremented `stage_idx` are all visible after edge T+1.
  - A sample presented after edge T+1 is accepted into the next stage.
- `done` is high for exactly one cycle, one cycle after the final `shift_valid`. `busy` is low in that cycle.
- `shift_value` changes only on the `UPDATE` edge or on `start`. It is never glitched mid-stage.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Reset mid-`MEASURE`** (bench parameters `FRAME_LEN=4`, `NUM_STAGES=3` for all scenarios):
  - Stimulus: `start`, 2 samples, then `rst_n` low.
  - Response: immediately `busy=0`, `shift_value=12`, `stage_idx=0`, `exp_total=0`; no `done`.
- **Fit boundary:**
  - Stage samples re = {1000, -3, 0, 7}, im = 0 → `shift_value=12`, `r=0`.
  - Next stage max re = 1024 → `shift_value=11`, `exp_total=1`.
  - Next stage re = -1025 → `shift_value=11`, `exp_total=2`, then `done` one cycle later.
- **Full range:** every sample re = 2^21-1 → `r=11`, `shift_value=1`. Every sample re = -2^22 → `r=12`, `shift_value=0`.
- **All-zero / -1 stage:** samples 0 and -1 only → `acc=0`, `shift_value=12`, `exp_total` unchanged.
- **Overrun and ignored start:** `in_valid` held high through `UPDATE` → `overrun=1`, that sample does not count toward the next stage; `start` during `busy` is ignored; next `start` clears `overrun`.
- **Back-to-back frames:** `start` on the cycle after `done` → `exp_total` cleared and `stage_idx=0`. Also check that `in_valid` gaps mid-stage stall the count without losing samples.
